// File: rtl/scope_acq_sequencer.sv
// Oscilloscope acquisition sequencer: fills pre-trigger history, qualifies a
// trigger, captures post-trigger samples into a circular buffer, flags done.
module scope_acq_sequencer #(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned DEC_W        = 17,
   parameter logic        TRIG_ACT_LVL = 1'b0
) (
   input  logic              adc_clk_i,
   input  logic              adc_rstn_i,
   input  logic              arm_i,
   input  logic              sw_rst_i,
   input  logic [3:0]        trig_src_i,
   input  logic              trig_sw_i,
   input  logic [3:0]        trig_cmp_i,
   input  logic              trig_ext_i,
   input  logic [DEC_W-1:0]  dec_i,
   input  logic [31:0]       pre_dly_i,
   input  logic [31:0]       post_dly_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_ptr_o,
   output logic [ADDR_W-1:0] trig_ptr_o,
   output logic              trig_o,
   output logic [2:0]        state_o,
   output logic              done_o
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   localparam logic [DEC_W-1:0]  DEC_ONE  = DEC_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [DEC_W-1:0]  div_q, div_d, dec_eff;
   logic [31:0]       pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
   logic [ADDR_W-1:0] wr_ptr_d, trig_ptr_d;
   logic              wr_en_d, done_d, accept, smp;

   logic              ext_s1, ext_s2, ext_s3;
   logic [3:0]        cmp_q1, cmp_q2, cmp_rise, cmp_fall;
   logic              ext_act, ext_act_q, trig_hit;

   function automatic logic in_acq(input state_t s);
      return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
   endfunction

   // Comparator inputs are registered once before edge detection; the external
   // trigger goes through two synchroniser flops plus one history flop.
   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         ext_s1 <= ~TRIG_ACT_LVL;
         ext_s2 <= ~TRIG_ACT_LVL;
         ext_s3 <= ~TRIG_ACT_LVL;
         cmp_q1 <= '0;
         cmp_q2 <= '0;
      end else begin
         ext_s1 <= trig_ext_i;
         ext_s2 <= ext_s1;
         ext_s3 <= ext_s2;
         cmp_q1 <= trig_cmp_i;
         cmp_q2 <= cmp_q1;
      end
   end

   assign ext_act   = (ext_s2 == TRIG_ACT_LVL);
   assign ext_act_q = (ext_s3 == TRIG_ACT_LVL);
   assign cmp_rise  = cmp_q1 & ~cmp_q2;
   assign cmp_fall  = ~cmp_q1 & cmp_q2;

   always_comb begin
      case (trig_src_i)
         4'd1:    trig_hit = trig_sw_i;
         4'd2:    trig_hit = cmp_rise[0];
         4'd3:    trig_hit = cmp_fall[0];
         4'd4:    trig_hit = cmp_rise[1];
         4'd5:    trig_hit = cmp_fall[1];
         4'd6:    trig_hit = cmp_rise[2];
         4'd7:    trig_hit = cmp_fall[2];
         4'd8:    trig_hit = cmp_rise[3];
         4'd9:    trig_hit = cmp_fall[3];
         4'd10:   trig_hit = ext_act & ~ext_act_q;
         4'd11:   trig_hit = ~ext_act & ext_act_q;
         default: trig_hit = 1'b0;
      endcase
   end

   assign dec_eff = (dec_i == '0) ? DEC_ONE : dec_i;
   assign smp     = in_acq(state_q) && (div_q == dec_eff - DEC_ONE);

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      div_d      = in_acq(state_q) ? (smp ? '0 : div_q + DEC_ONE) : '0;
      pre_cnt_d  = pre_cnt_q;
      post_cnt_d = post_cnt_q;
      wr_ptr_d   = wr_en_o ? wr_ptr_o + ADDR_ONE : wr_ptr_o;
      trig_ptr_d = trig_ptr_o;
      accept     = 1'b0;

      case (state_q)
         ST_PRE: begin
            if (wr_en_o)
               pre_cnt_d = (pre_cnt_q == '1) ? pre_cnt_q : pre_cnt_q + 32'd1;
            if ((pre_dly_i == '0) || (wr_en_o && (pre_cnt_d >= pre_dly_i)))
               state_d = ST_WAIT_TRIG;
         end
         ST_WAIT_TRIG: begin
            if (trig_hit) begin
               accept     = 1'b1;
               trig_ptr_d = wr_ptr_d;
               state_d    = ST_POST;
            end
         end
         ST_POST: begin
            if (post_dly_i == '0) begin
               state_d = ST_DONE;
            end else if (wr_en_o) begin
               post_cnt_d = post_cnt_q + 32'd1;
               if (post_cnt_d == post_dly_i)
                  state_d = ST_DONE;
            end
         end
         ST_IDLE, ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase

      // Abort outranks arm; both restart the write pointer but keep trig_ptr_o.
      if (sw_rst_i || arm_i) begin
         state_d    = sw_rst_i ? ST_IDLE : ST_PRE;
         div_d      = '0;
         pre_cnt_d  = '0;
         post_cnt_d = '0;
         wr_ptr_d   = '0;
         trig_ptr_d = trig_ptr_o;
         accept     = 1'b0;
      end

      // A strobe becomes a write only if the next state still acquires; a
      // zero-length post window must not write after the trigger.
      wr_en_d = smp && in_acq(state_d) && !sw_rst_i && !arm_i &&
                !(accept && (post_dly_i == '0));
      done_d  = (state_d == ST_DONE);
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         div_q      <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         wr_en_o    <= 1'b0;
         wr_ptr_o   <= '0;
         trig_ptr_o <= '0;
         trig_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         div_q      <= div_d;
         pre_cnt_q  <= pre_cnt_d;
         post_cnt_q <= post_cnt_d;
         wr_en_o    <= wr_en_d;
         wr_ptr_o   <= wr_ptr_d;
         trig_ptr_o <= trig_ptr_d;
         trig_o     <= accept;
         done_o     <= done_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: doc/scope_acq_sequencer.md
SCOPE_ACQ_SEQUENCER -- requirements
Module: scope_acq_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, giving the capture-buffer address width.
REQ-002 SHALL have parameter DEC_W, default 17, giving the decimation factor width.
REQ-003 SHALL have parameter TRIG_ACT_LVL, default 0, giving the active level of the external trigger.
REQ-004 SHALL have ports, in this order:
- adc_clk_i  in  1  the single clock for the block.
- adc_rstn_i  in  1  reset, asynchronous, active-low.
- arm_i  in  1  one-cycle arm request.
- sw_rst_i  in  1  one-cycle abort request.
- trig_src_i  in  4  trigger source select.
- trig_sw_i  in  1  software trigger pulse.
- trig_cmp_i  in  4  channel comparator levels for ch A..D.
- trig_ext_i  in  1  asynchronous external trigger.
- dec_i  in  DEC_W  decimation factor.
- pre_dly_i  in  32  minimum pre-trigger sample count.
- post_dly_i  in  32  post-trigger sample count.
- wr_en_o  out  1  buffer write strobe.
- wr_ptr_o  out  ADDR_W  buffer write address.
- trig_ptr_o  out  ADDR_W  address of the trigger sample.
- trig_o  out  1  one-cycle accepted-trigger pulse.
- state_o  out  3  current state encoding.
- done_o  out  1  acquisition complete.

Function
REQ-005 SHALL implement states IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4, and SHALL present the current state on state_o.
REQ-006 SHALL produce a sample strobe on every dec_i-th cycle while in PRE, WAIT_TRIG or POST; dec_i=0 SHALL act as 1; the strobe divider SHALL clear on arm.
REQ-007 SHALL drive wr_en_o as a copy of the sample strobe, and SHALL hold it at 0 in IDLE and DONE.
REQ-008 SHALL increment wr_ptr_o after each write and wrap it modulo 2^ADDR_W.
REQ-009 SHALL, on arm_i in any state, clear wr_ptr_o, the pre/post counters and done_o, and enter PRE.
REQ-010 SHALL count writes in PRE with a saturating counter, and SHALL move PRE->WAIT_TRIG on the cycle the count reaches pre_dly_i; pre_dly_i=0 SHALL pass straight to WAIT_TRIG on the cycle after arm.
REQ-011 SHALL decode trig_src_i as follows:
- 0: disabled.
- 1: trig_sw_i.
- 2+2k: rising edge of trig_cmp_i[k], k=0..3.
- 3+2k: falling edge of trig_cmp_i[k], k=0..3.
- 10: ext edge into active level.
- 11: ext edge out of active level.
- 12..15: disabled.
REQ-012 SHALL pass trig_ext_i through a 2-flop synchroniser; the ext active level SHALL be trig_ext_i==TRIG_ACT_LVL.
REQ-013 SHALL take edges from registered previous values, so edge detect adds one cycle after the source (three cycles for ext).
REQ-014 SHALL accept a trigger only in WAIT_TRIG; in that case it SHALL pulse trig_o, load trig_ptr_o with the address of the next write, and enter POST.
REQ-015 SHALL ignore triggers in IDLE, PRE, POST and DONE, including a trigger in the cycle PRE exits.
REQ-016 SHALL count writes in POST, and SHALL enter DONE and set done_o on the cycle the count equals post_dly_i; post_dly_i=0 SHALL enter DONE the cycle after trigger with no POST writes.
REQ-017 SHALL allow post_dly_i ≥ 2^ADDR_W, in which case older data is overwritten; no error is raised.
REQ-018 SHALL hold done_o until the next arm_i or sw_rst_i.
REQ-019 SHALL give sw_rst_i priority over arm_i, and SHALL apply it in any state: go to IDLE, clear done_o, wr_ptr_o and counters, and retain trig_ptr_o.
REQ-020 SHALL sample trig_src_i, dec_i, pre_dly_i and post_dly_i continuously, and software SHALL change them only in IDLE/DONE.

Reset
REQ-021 SHALL, with adc_rstn_i low, asynchronously force state IDLE, wr_en_o=0, wr_ptr_o=0, trig_ptr_o=0, trig_o=0, done_o=0, all counters 0 and synchroniser/edge flops inactive.
REQ-022 SHALL register all outputs, and release of reset SHALL cause no trig_o pulse.

Verification
REQ-023 Bench SHALL check: dec=1, pre=8, post=4, src=1, trig_sw at cycle 20 after arm -> 8 PRE writes, trig_o once, trig_ptr_o=value at acceptance, exactly 4 more writes, done_o=1, state_o=4.
REQ-024 Bench SHALL check: dec=4, pre=3, src=2, trig_cmp_i[0] 0->1 in PRE then again in WAIT_TRIG -> first edge ignored, second accepted; wr_en_o spacing exactly 4 cycles.
REQ-025 Bench SHALL check: ADDR_W=4, pre=0, post=40, src=10, TRIG_ACT_LVL=0, trig_ext_i 1->0 -> trig_o 3 cycles later, wr_ptr_o wraps 15->0, final wr_ptr_o=(trig_ptr_o+40) mod 16.
REQ-026 Bench SHALL check: sw_rst_i and arm_i in the same cycle during POST -> IDLE, done_o=0, no further writes.
REQ-027 Bench SHALL check: adc_rstn_i low mid-POST -> all outputs 0 immediately, without a clock edge; after release, state IDLE until arm.
REQ-028 Bench SHALL check: dec=0, post=0, src=13 -> triggers never accepted; with src=1 and post=0 -> DONE one cycle after trig_o.
